// File: rtl/contador_cascata.sv
// Cascaded multi-digit countdown timer with run/pause/done control.
// Each digit has its own modulus; a tick borrows through the chain.
module contador_cascata #(
  parameter int NDIG = 4,
  parameter int DW = 4,
  parameter logic [NDIG*DW-1:0] MODULI = {4'd6, 4'd10, 4'd6, 4'd10}
) (
  input  logic               clk,
  input  logic               clear,
  input  logic [NDIG*DW-1:0] data,
  input  logic               load,
  input  logic               start,
  input  logic               pause,
  input  logic               cancel,
  input  logic               tick,
  output logic [NDIG*DW-1:0] count,
  output logic               tc,
  output logic               running,
  output logic               done,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int W = NDIG * DW;

  state_t         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic           running_q, running_d;
  logic           done_q, done_d;

  logic [W-1:0]   ld_val;
  logic [W-1:0]   dec_val;
  logic           last_unit;
  logic           is_run;
  logic           do_cancel, do_load, do_pause;
  logic           do_start, do_tick;

  assign tc        = (count_q == '0);
  assign is_run    = (state_q == RUN);
  assign last_unit = (count_q == W'(1));

  // A modulus field of zero encodes 2^DW, so it never clamps.
  always_comb begin
    logic [DW-1:0] m;
    logic [DW-1:0] v;
    ld_val = '0;
    for (int i = 0; i < NDIG; i++) begin
      m = MODULI[i*DW +: DW];
      v = data[i*DW +: DW];
      if (m != '0 && v >= m) v = m - 1'b1;
      ld_val[i*DW +: DW] = v;
    end
  end

  always_comb begin
    logic borrow;
    logic [DW-1:0] m;
    dec_val = count_q;
    borrow  = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      m = MODULI[i*DW +: DW];
      if (borrow) begin
        if (count_q[i*DW +: DW] == '0) begin
          dec_val[i*DW +: DW] = m - 1'b1;
        end else begin
          dec_val[i*DW +: DW] = count_q[i*DW +: DW] - 1'b1;
          borrow = 1'b0;
        end
      end
    end
  end

  // Ignored requests fall through to lower-priority ones.
  always_comb begin
    do_cancel = cancel;
    do_load   = !do_cancel && load && !is_run;
    do_pause  = !do_cancel && !do_load && pause && is_run;
    do_start  = !do_cancel && !do_load && !do_pause && start
                && (state_q == IDLE || state_q == PAUSE) && !tc;
    do_tick   = !do_cancel && !do_load && !do_pause && !do_start
                && tick && is_run;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    unique case (1'b1)
      do_cancel: begin
        count_d = '0;
        state_d = IDLE;
      end
      do_load: begin
        count_d = ld_val;
        if (state_q == DONE) state_d = IDLE;
      end
      do_pause: state_d = PAUSE;
      do_start: state_d = RUN;
      do_tick: begin
        if (last_unit) begin
          count_d = '0;
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          count_d = dec_val;
        end
      end
      default: ;
    endcase
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      state_q   <= IDLE;
      count_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign count   = count_q;
  assign running = running_q;
  assign done    = done_q;
  assign state   = state_q;

endmodule

// File: tb/tb_contador_cascata.sv
// Directed bench for contador_cascata (mm:ss default moduli).
// Digits pack as hex nibbles, so 16'h0105 is 01:05.
module tb_contador_cascata;

  logic        clk = 1'b0;
  logic        clear, load, start, pause, cancel, tick;
  logic [15:0] data;
  logic [15:0] count;
  logic        tc, running, done;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  contador_cascata dut (
    .clk     (clk),
    .clear   (clear),
    .data    (data),
    .load    (load),
    .start   (start),
    .pause   (pause),
    .cancel  (cancel),
    .tick    (tick),
    .count   (count),
    .tc      (tc),
    .running (running),
    .done    (done),
    .state   (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    load = 0; start = 0; pause = 0; cancel = 0; tick = 0; clear = 1;
  endtask

  // Apply current inputs for one edge, then release them.
  task automatic cyc();
    @(posedge clk);
    #1;
    idle_in();
  endtask

  task automatic do_load(input logic [15:0] v);
    data = v; load = 1; cyc();
  endtask

  task automatic do_start();
    start = 1; cyc();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1; cyc();
    end
  endtask

  initial begin
    idle_in();
    data = '0;
    @(negedge clk);
    clear = 0;
    @(posedge clk);
    #1;
    idle_in();
    chk("rst_count", count, 16'h0000);
    chk("rst_state", state, S_IDLE);
    chk("rst_tc", tc, 1);
    chk("rst_running", running, 0);
    chk("rst_done", done, 0);

    do_load(16'h0105);
    chk("ld_0105", count, 16'h0105);
    chk("ld_tc", tc, 0);
    start = 1; tick = 1; cyc();
    chk("start_run", state, S_RUN);
    chk("start_running", running, 1);
    chk("start_tick_ign", count, 16'h0105);
    ticks(5);
    chk("borrow_0100", count, 16'h0100);
    ticks(1);
    chk("borrow_0059", count, 16'h0059);
    pause = 1; cyc();
    do_load(16'h1000);
    do_start();
    ticks(1);
    chk("borrow_0959", count, 16'h0959);

    cancel = 1; cyc();
    do_load(16'h0002);
    do_start();
    ticks(1);
    chk("tc_0001", count, 16'h0001);
    ticks(1);
    chk("tc_zero", count, 16'h0000);
    chk("tc_state", state, S_DONE);
    chk("tc_done1", done, 1);
    chk("tc_running", running, 0);
    ticks(1);
    chk("tc_done0", done, 0);
    ticks(2);
    do_start();
    chk("done_hold_cnt", count, 16'h0000);
    chk("done_hold_st", state, S_DONE);
    chk("done_hold_pulse", done, 0);

    do_load(16'h0030);
    chk("ld_from_done", state, S_IDLE);
    do_start();
    pause = 1; tick = 1; cyc();
    chk("pause_state", state, S_PAUSE);
    chk("pause_count", count, 16'h0030);
    chk("pause_running", running, 0);
    ticks(3);
    chk("pause_hold", count, 16'h0030);
    do_start();
    ticks(1);
    chk("resume_0029", count, 16'h0029);

    pause = 1; cyc();
    do_load(16'h007C);
    chk("clamp_lo", count, 16'h0059);
    chk("clamp_state", state, S_PAUSE);
    do_load(16'hFFFF);
    chk("clamp_all", count, 16'h5959);
    do_start();
    do_load(16'h0300);
    chk("ld_in_run", count, 16'h5959);
    chk("ld_in_run_st", state, S_RUN);
    cancel = 1; cyc();
    do_load(16'h0000);
    do_start();
    chk("start_zero_st", state, S_IDLE);
    chk("start_zero_tc", tc, 1);
    chk("start_zero_run", running, 0);

    do_load(16'h0517);
    do_start();
    cancel = 1; cyc();
    chk("cancel_cnt", count, 16'h0000);
    chk("cancel_st", state, S_IDLE);
    chk("cancel_done", done, 0);
    do_load(16'h0517);
    do_start();
    ticks(1);
    chk("run_0516", count, 16'h0516);
    clear = 0; cyc();
    chk("clr_cnt", count, 16'h0000);
    chk("clr_st", state, S_IDLE);
    chk("clr_done", done, 0);
    chk("clr_running", running, 0);
    do_load(16'h0001);
    do_start();
    cancel = 1; tick = 1; cyc();
    chk("cxl_last_done", done, 0);
    chk("cxl_last_st", state, S_IDLE);
    chk("cxl_last_cnt", count, 16'h0000);
    cyc();
    chk("cxl_last_done2", done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
